// File: rtl/sgm_pkg.sv
// rtl/sgm_pkg.sv - shared types and sizing helpers for the SGM line-buffer sequencer
package sgm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    FLUSH
  } ctrl_state_t;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
  } line_tag_t;

  function automatic int calc_beats(input int pixels_per_line, input int samples_per_clock);
    return pixels_per_line / samples_per_clock;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sgm_linebuf_ctrl_if.sv
// rtl/sgm_linebuf_ctrl_if.sv - input/output stream sideband handshake bundle
interface sgm_linebuf_ctrl_if;

  logic s_tvalid;
  logic s_tready;
  logic s_tuser;
  logic s_tlast;
  logic m_tvalid;
  logic m_tready;
  logic m_tuser;
  logic m_tlast;

  modport master (
    output s_tvalid, s_tuser, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tuser, m_tlast
  );

  modport slave (
    input  s_tvalid, s_tuser, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tuser, m_tlast
  );

endinterface

// File: rtl/sgm_tag_pipe.sv
// rtl/sgm_tag_pipe.sv - line tag delay matched to the delay-line read latency
module sgm_tag_pipe
  import sgm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ce_i,
  input  line_tag_t tag_i,
  output line_tag_t tag_o,
  output logic      nonempty_o
);

  line_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (ce_i) begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

  always_comb begin
    nonempty_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) nonempty_o = nonempty_o | stage_q[i].valid;
  end

endmodule

// File: rtl/sgm_linebuf_ctrl.sv
// rtl/sgm_linebuf_ctrl.sv - ce/tlast/pad sequencer and output sideband for the SGM line buffers
module sgm_linebuf_ctrl
  import sgm_pkg::*;
#(
  parameter int MAX_SAMPLES_PER_CLOCK = 4,
  parameter int PIXELS_PER_LINE       = 64,
  parameter int LINES_PER_FRAME       = 48,
  parameter int WINDOW_LINES          = 3,
  parameter int PIPE_LATENCY          = 2
) (
  input  logic              clk,
  input  logic              rst,
  sgm_linebuf_ctrl_if.slave axis,
  output logic              ce,
  output logic              line_tlast,
  output logic              pad,
  output logic              busy,
  output logic              err_line,
  output logic              err_frame
);

  localparam int K     = WINDOW_LINES;
  localparam int BEATS = calc_beats(PIXELS_PER_LINE, MAX_SAMPLES_PER_CLOCK);
  localparam int COL_W = cnt_width(BEATS);
  localparam int ROW_W = cnt_width(LINES_PER_FRAME + K);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(BEATS - 1);
  localparam logic [ROW_W-1:0] FIRST_OUT = ROW_W'(K - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(LINES_PER_FRAME - 1);
  localparam logic [ROW_W-1:0] LAST_PAD  = ROW_W'(LINES_PER_FRAME + K - 2);
  localparam ctrl_state_t END_STATE = (K > 1) ? FLUSH : IDLE;

  ctrl_state_t      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, eff_col;
  logic [ROW_W-1:0] row_q, row_d, eff_row, row_inc;
  logic             out_en_q;
  logic             m_tvalid_q, m_tuser_q, m_tlast_q, err_line_q, err_frame_q;
  logic             m_tvalid_d, m_tuser_d, m_tlast_d, err_line_d, err_frame_d;
  logic             stall, pipe_nonempty, s_tready_c;
  logic             in_beat, sof_acc, flush_beat, col_end, line_end;
  line_tag_t        tag_in, tag_out;

  assign stall = m_tvalid_q & ~axis.m_tready;

  always_comb begin
    s_tready_c  = 1'b0;
    ce          = 1'b0;
    line_tlast  = 1'b0;
    pad         = 1'b0;
    in_beat     = 1'b0;
    sof_acc     = 1'b0;
    flush_beat  = 1'b0;
    if (out_en_q) begin
      case (state_q)
        IDLE: begin
          if (pipe_nonempty) begin
            ce  = ~stall;
            pad = 1'b1;
          end else begin
            s_tready_c = ~stall;
            sof_acc    = axis.s_tvalid & axis.s_tuser & ~stall;
            in_beat    = sof_acc;
          end
        end
        PRIME, RUN: begin
          s_tready_c = ~stall;
          in_beat    = axis.s_tvalid & ~stall;
          sof_acc    = in_beat & axis.s_tuser;
        end
        FLUSH: begin
          ce         = ~stall;
          pad        = 1'b1;
          flush_beat = ~stall;
        end
        default: ;
      endcase
    end

    // A SOF beat is always column 0 of row 0, whatever the counters held.
    eff_col  = sof_acc ? '0 : col_q;
    eff_row  = sof_acc ? '0 : row_q;
    row_inc  = eff_row + ROW_W'(1);
    col_end  = (eff_col == LAST_COL);
    line_end = col_end | (in_beat & axis.s_tlast);
    if (in_beat) begin
      ce         = 1'b1;
      line_tlast = line_end;
    end
    if (flush_beat) line_tlast = col_end;

    tag_in.valid = (in_beat & (eff_row >= FIRST_OUT)) | flush_beat;
    tag_in.sof   = in_beat & (eff_row == FIRST_OUT) & (eff_col == '0);
    tag_in.eol   = tag_in.valid & line_end;

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_beat) begin
      if (line_end) begin
        col_d = '0;
        if (eff_row == LAST_ROW) begin
          row_d   = (K > 1) ? row_inc : '0;
          state_d = END_STATE;
        end else begin
          row_d   = row_inc;
          state_d = (row_inc >= FIRST_OUT) ? RUN : PRIME;
        end
      end else begin
        col_d   = eff_col + COL_W'(1);
        row_d   = eff_row;
        state_d = (eff_row >= FIRST_OUT) ? RUN : PRIME;
      end
    end else if (flush_beat) begin
      if (col_end) begin
        col_d = '0;
        if (row_q == LAST_PAD) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    err_line_d  = err_line_q | (in_beat & (axis.s_tlast ^ col_end));
    err_frame_d = err_frame_q | (in_beat & axis.s_tuser & (state_q != IDLE));

    // ce never fires under stall, so loading a new tag cannot overwrite a held beat.
    m_tvalid_d = m_tvalid_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    if (ce) begin
      m_tvalid_d = tag_out.valid;
      m_tuser_d  = tag_out.valid & tag_out.sof;
      m_tlast_d  = tag_out.valid & tag_out.eol;
    end else if (axis.m_tready) begin
      m_tvalid_d = 1'b0;
      m_tuser_d  = 1'b0;
      m_tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_en_q    <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tuser_q   <= 1'b0;
      m_tlast_q   <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_en_q    <= 1'b1;
      m_tvalid_q  <= m_tvalid_d;
      m_tuser_q   <= m_tuser_d;
      m_tlast_q   <= m_tlast_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  sgm_tag_pipe #(
    .DEPTH(PIPE_LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce),
    .tag_i      (tag_in),
    .tag_o      (tag_out),
    .nonempty_o (pipe_nonempty)
  );

  assign axis.s_tready = s_tready_c;
  assign axis.m_tvalid = m_tvalid_q;
  assign axis.m_tuser  = m_tuser_q;
  assign axis.m_tlast  = m_tlast_q;
  assign busy          = (state_q != IDLE) | pipe_nonempty;
  assign err_line      = err_line_q;
  assign err_frame     = err_frame_q;

endmodule

// File: tb/tb_sgm_linebuf_ctrl.sv
// tb/tb_sgm_linebuf_ctrl.sv - scoreboard bench for the SGM line-buffer sequencer
module tb_sgm_linebuf_ctrl;

  localparam int PPC   = 4;
  localparam int PPL   = 64;
  localparam int LINES = 4;
  localparam int K     = 3;
  localparam int LAT   = 2;
  localparam int BEATS = PPL / PPC;
  localparam int FRAME_CE = LINES * BEATS + (K - 1) * BEATS + LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce, line_tlast, pad, busy, err_line, err_frame;

  sgm_linebuf_ctrl_if bus();

  sgm_linebuf_ctrl #(
    .MAX_SAMPLES_PER_CLOCK (PPC),
    .PIXELS_PER_LINE       (PPL),
    .LINES_PER_FRAME       (LINES),
    .WINDOW_LINES          (K),
    .PIPE_LATENCY          (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .axis       (bus),
    .ce         (ce),
    .line_tlast (line_tlast),
    .pad        (pad),
    .busy       (busy),
    .err_line   (err_line),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  int         checks;
  int         errors;
  int         ce_cnt;
  int         stall_ce;
  bit         rand_ready;
  logic [1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic monitor();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ce) ce_cnt++;
        if (ce && bus.m_tvalid && !bus.m_tready) stall_ce++;
        if (bus.m_tvalid && bus.m_tready) begin
          check_eq("beat_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("out_tag_sof_eol", {30'd0, bus.m_tuser, bus.m_tlast}, {30'd0, e});
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      bus.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send_beat(input logic user, input logic last, input logic exp_lt, input logic exp_ce);
    int n;
    n = 0;
    bus.s_tvalid = 1'b1;
    bus.s_tuser  = user;
    bus.s_tlast  = last;
    @(negedge clk);
    while (!bus.s_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat_accept", 32'(bus.s_tready), 1);
    check_eq("ce_on_beat", 32'(ce), 32'(exp_ce));
    check_eq("line_tlast", 32'(line_tlast), 32'(exp_lt));
    @(posedge clk);
    #1;
    bus.s_tvalid = 1'b0;
    bus.s_tuser  = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic send_row(input int len, input bit sof);
    for (int i = 0; i < len; i++)
      send_beat(sof && i == 0, i == len - 1, i == len - 1, 1'b1);
  endtask

  task automatic push_frame();
    for (int l = 0; l < LINES; l++)
      for (int b = 0; b < BEATS; b++)
        exp_q.push_back({l == 0 && b == 0, b == BEATS - 1});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || bus.m_tvalid || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", 32'(n < 3000), 1);
    check_eq("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag);
    int c0;
    c0 = ce_cnt;
    push_frame();
    for (int r = 0; r < LINES; r++) send_row(BEATS, r == 0);
    wait_idle();
    check_eq(tag, ce_cnt - c0, FRAME_CE);
  endtask

  initial begin
    int c0;
    checks       = 0;
    errors       = 0;
    ce_cnt       = 0;
    stall_ce     = 0;
    rand_ready   = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tuser  = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b1;
    fork
      monitor();
      ready_drv();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             {22'd0, ce, line_tlast, pad, busy, err_line, err_frame,
              bus.s_tready, bus.m_tvalid, bus.m_tuser, bus.m_tlast}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("tready_after_rst_drop", 32'(bus.s_tready), 0);
    @(posedge clk);
    #1;
    check_eq("tready_next_cycle", 32'(bus.s_tready), 1);

    run_frame("ce_count_basic");
    check_eq("err_line_clean", 32'(err_line), 0);
    check_eq("err_frame_clean", 32'(err_frame), 0);

    rand_ready = 1'b1;
    run_frame("ce_count_backpressure");
    check_eq("ce_during_stall", stall_ce, 0);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send_beat(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("drop_no_busy", 32'(busy), 0);
    check_eq("drop_no_output", 32'(bus.m_tvalid), 0);
    run_frame("ce_count_after_drop");

    reset_dut();
    c0 = ce_cnt;
    push_frame();
    send_row(BEATS, 1'b1);
    check_eq("err_line_before", 32'(err_line), 0);
    send_row(10, 1'b0);
    check_eq("err_line_short_row", 32'(err_line), 1);
    send_row(BEATS, 1'b0);
    send_row(BEATS, 1'b0);
    wait_idle();
    check_eq("ce_count_short_row", ce_cnt - c0, 3 * BEATS + 10 + (K - 1) * BEATS + LAT);

    reset_dut();
    c0 = ce_cnt;
    exp_q.push_back(2'b10);
    for (int i = 0; i < 4; i++) exp_q.push_back(2'b00);
    push_frame();
    send_row(BEATS, 1'b1);
    send_row(BEATS, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("err_frame_before", 32'(err_frame), 0);
    send_row(BEATS, 1'b1);
    check_eq("err_frame_restart", 32'(err_frame), 1);
    for (int r = 1; r < LINES; r++) send_row(BEATS, 1'b0);
    wait_idle();
    check_eq("ce_count_restart", ce_cnt - c0, 2 * BEATS + 5 + FRAME_CE);

    push_frame();
    for (int r = 0; r < LINES; r++) send_row(BEATS, r == 0);
    repeat (6) @(posedge clk);
    check_eq("flush_busy", 32'(busy), 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_flush_outputs",
             {22'd0, ce, line_tlast, pad, busy, err_line, err_frame,
              bus.s_tready, bus.m_tvalid, bus.m_tuser, bus.m_tlast}, 0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    run_frame("ce_count_after_rst");
    check_eq("err_frame_after_rst", 32'(err_frame), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sgm_linebuf_ctrl.md
# sgm_linebuf_ctrl

Sequencer for the SGM line-buffer stage. It accepts the pixel stream handshake and generates the shared `ce`/`tlast` strobes for the chain of dual-BRAM delay lines. It primes the buffers at frame start and flushes them with padding lines at frame end. It emits the output-side stream sideband (valid/SOF/EOL) aligned to the delay-line read latency. It carries no pixel data: the datapath muxes padding and samples delay-line outputs under its control.

## Interface
- `MAX_SAMPLES_PER_CLOCK`, 4: pixels per beat (ppc).
- `PIXELS_PER_LINE`, 64: image width; must be a multiple of ppc. BEATS = PIXELS_PER_LINE/MAX_SAMPLES_PER_CLOCK.
- `LINES_PER_FRAME`, 48: image height, at least `WINDOW_LINES`.
- `WINDOW_LINES`, 3: K, the rows in the vertical window (K-1 delay lines), at least 1.
- `PIPE_LATENCY`, 2: ce-advances from a delay-line write to its aligned output (BRAM read plus output register).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_tvalid`  in  1  input beat valid.
- `s_tready`  out  1  input beat accepted when high with `s_tvalid`.
- `s_tuser`  in  1  start of frame, on the first beat.
- `s_tlast`  in  1  end of line.
- `ce`  out  1  advance strobe to all delay lines and datapath registers.
- `line_tlast`  out  1  end-of-line strobe to delay lines; only asserted together with `ce`.
- `pad`  out  1  datapath selects zero padding instead of `s` data for the current `ce`.
- `m_tvalid`  out  1  output beat valid.
- `m_tready`  in  1  downstream ready.
- `m_tuser`  out  1  first output beat of the frame.
- `m_tlast`  out  1  last beat of an output line.
- `busy`  out  1  state != IDLE, or the tag pipe is not empty.
- `err_line`  out  1  sticky: line length mismatch.
- `err_frame`  out  1  sticky: SOF received mid-frame.

## Operation
- Counters:
  - col: width clog2(BEATS), wraps at BEATS-1.
  - row: width clog2(LINES_PER_FRAME+K), resets at frame start.
- stall = m_tvalid & ~m_tready. No `ce` is asserted while stall is high.
- States:
  - IDLE:
    - `s_tready`=1 when the tag pipe is empty.
    - Beats without `s_tuser` are dropped, with `ce`=0.
    - An accepted beat with `s_tuser` gives `ce`, row=0, col=1, and moves to PRIME.
    - If tags are still valid (drain), then `s_tready`=0, `ce`=~stall and `pad`=1 until the pipe is empty.
  - PRIME (rows 0..K-2):
    - `ce` = s_tvalid & s_tready; `s_tready` = ~stall.
    - Tags are pushed invalid.
    - Moves to RUN on the last beat of row K-2; if K=1, moves straight from IDLE to RUN.
  - RUN:
    - As PRIME, but tags are valid.
    - The tag is marked SOF for the first beat of row K-1 and EOL for the last beat of each line.
    - On the last beat of row LINES_PER_FRAME-1, moves to FLUSH (K>1) or IDLE (K=1).
  - FLUSH:
    - `s_tready`=0.
    - Generates (K-1)·BEATS internal beats with `ce`=~stall, `pad`=1, valid tags, and EOL at col BEATS-1.
    - After the last beat, moves to IDLE (drain).
- Output frame:
  - Exactly LINES_PER_FRAME lines of BEATS beats.
  - Output row o corresponds to input row o+K-1.
- Line end:
  - `line_tlast`=1 on a beat at col BEATS-1, or on an input beat with `s_tlast`.
  - If `s_tlast` arrives with col≠BEATS-1, or col=BEATS-1 arrives without `s_tlast`: set `err_line`, and end the line at whichever comes first.
- An accepted `s_tuser` beat in PRIME/RUN sets `err_frame` and restarts the frame: row=0, col=1, state PRIME. Tags already in the pipe drain unchanged.
- FLUSH/drain `s_tuser` is not accepted (`s_tready`=0).

## Timing
- Reset values:
  - `s_tready`=0, `ce`=0, `line_tlast`=0, `pad`=0.
  - `m_tvalid`=0, `m_tuser`=0, `m_tlast`=0, `busy`=0.
  - Both err flags 0; state IDLE; counters 0; tag pipe cleared.
  - `s_tready` rises the cycle after `rst` drops.
- `s_tready`, `ce`, `line_tlast` and `pad` are combinational from state, counters, `s_tvalid` and stall.
- Tag pipe:
  - PIPE_LATENCY stages, advancing only on `ce`.
  - The `m_*` outputs reflect the tag shifted out by the `ce` PIPE_LATENCY advances after its write, registered the cycle after that `ce`.
  - `m_tvalid` holds, with `m_tuser` and `m_tlast` stable, until `m_tready`.
- Back-pressure: the cycle after `m_tready` falls with `m_tvalid`=1, `ce`=0. No beat is lost or duplicated.
- `rst` mid-frame: everything returns to reset values on the next edge. Delay-line contents are don't-care.

## Structure
- Package `sgm_pkg`:
  - `ctrl_state_t` enum {IDLE, PRIME, RUN, FLUSH}.
  - `line_tag_t` struct {valid, sof, eol}.
  - Helper localparam functions for BEATS and counter widths.
- Sub-module `sgm_tag_pipe`: parameterised shift register of `line_tag_t` with enable `ce`, depth PIPE_LATENCY, and a `nonempty` output.

## Test plan
- K=3, BEATS=16, LINES=4, m_tready=1, continuous input:
  - `ce` count = 64 input + 32 flush + 2 drain.
  - `m_tvalid` beats = 64; `m_tuser` on the 1st; `m_tlast` on every 16th.
- Random `m_tready` (50%) on the same frame: the output tag sequence is identical to the previous case, and no `ce` occurs while stall=1.
- A beat without `s_tuser` in IDLE: accepted, `ce`=0, no output. The following SOF frame behaves as in the first scenario.
- `s_tlast` at col 9 of row 1: `line_tlast` at col 9, `err_line`=1, and the next beat is col 0.
- `s_tuser` at row 2, col 5: `err_frame`=1, state returns to PRIME; the first new `m_tuser` appears after 2 more full lines.
- `rst` during FLUSH: next cycle all outputs are 0 and `busy`=0; a new frame runs cleanly.
